// File: rtl/dac_spi_pkg.sv
// Shared constants for the DAC SPI frame receiver: frame geometry, AD5681R-style
// command codes and the receive FSM state encodings.
package dac_spi_pkg;

    localparam int FRAME_BITS_DEF = 24;
    localparam int DATA_BITS_DEF  = 16;
    localparam int CMD_BITS       = 4;

    // Field positions within a default 24-bit frame; bits [3:0] carry no information.
    localparam int CMD_MSB  = FRAME_BITS_DEF - 1;
    localparam int CMD_LSB  = FRAME_BITS_DEF - CMD_BITS;
    localparam int DATA_MSB = FRAME_BITS_DEF - CMD_BITS - 1;
    localparam int DATA_LSB = DATA_MSB - DATA_BITS_DEF + 1;

    typedef enum logic [3:0] {
        CMD_NOP          = 4'h0,
        CMD_WRITE_INPUT  = 4'h1,
        CMD_UPDATE_DAC   = 4'h2,
        CMD_WRITE_UPDATE = 4'h3,
        CMD_WRITE_CTRL   = 4'h4
    } dac_cmd_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_OVERRUN = 2'd2;

    function automatic int bit_count_width(input int frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

endpackage

// File: rtl/dac_spi_frame_receiver_if.sv
// DAC SPI pin bundle: the tone generator (or bench) drives it, the receiver listens.
interface dac_spi_if;
    logic spi_clk;
    logic spi_sync;
    logic data;

    modport master (output spi_clk, output spi_sync, output data);
    modport slave  (input  spi_clk, input  spi_sync, input  data);
endinterface

// File: rtl/dac_spi_frame_receiver_sync_edge_detect.sv
// Synchronizer for one asynchronous pin with a registered change pulse; level_o is
// the synchronized value aligned with change_o so callers can tell rise from fall.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic level_o,
    output logic change_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   change_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            hist_q   <= RESET_VAL;
            change_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q   <= sync_q[SYNC_STAGES-1];
            change_q <= sync_q[SYNC_STAGES-1] ^ hist_q;
        end
    end

    assign level_o  = hist_q;
    assign change_o = change_q;

endmodule

// File: rtl/dac_spi_frame_receiver.sv
// Decodes 24-bit DAC SPI frames into a command nibble and a 16-bit sample,
// flagging each frame as good (frame_valid) or malformed (frame_err).
module dac_spi_frame_receiver
    import dac_spi_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dac_spi_if.slave             spi,
    output logic [3:0]           cmd_out,
    output logic [DATA_BITS-1:0] data_dac,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [15:0]          frame_count,
    output logic                 busy
);

    localparam int CNT_W = bit_count_width(FRAME_BITS);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FRAME_BITS);

    logic sclk_level, sclk_change;
    logic sync_level, sync_change;
    logic sclk_fall, sync_rise, sync_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_i  (spi.spi_clk),
        .level_o  (sclk_level),
        .change_o (sclk_change)
    );

    // Resetting the spi_sync history low means a frame already in flight at reset
    // release shows no falling edge and is skipped until spi_sync returns high.
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_i  (spi.spi_sync),
        .level_o  (sync_level),
        .change_o (sync_change)
    );

    assign sclk_fall = sclk_change & ~sclk_level;
    assign sync_rise = sync_change &  sync_level;
    assign sync_fall = sync_change & ~sync_level;

    // One stage deeper than the synchronizer so the bit lines up with sclk_fall.
    logic [SYNC_STAGES:0] data_pipe_q;
    logic                 data_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_pipe_q <= '0;
        end else begin
            data_pipe_q <= {data_pipe_q[SYNC_STAGES-1:0], spi.data};
        end
    end

    assign data_s = data_pipe_q[SYNC_STAGES];

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  valid_pend_q, valid_pend_d;
    logic                  err_pend_q, err_pend_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        valid_pend_d = 1'b0;
        err_pend_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sync_fall) begin
                    state_d = ST_SHIFT;
                    sr_d    = '0;
                end
            end
            ST_SHIFT: begin
                // A clock edge coinciding with the end of frame is dropped; the
                // frame is judged on the bits counted before it.
                if (sync_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == FULL_COUNT) begin
                        valid_pend_d = 1'b1;
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (cnt_q == FULL_COUNT) begin
                        state_d = ST_OVERRUN;
                    end else begin
                        sr_d  = {sr_q[FRAME_BITS-2:0], data_s};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OVERRUN: begin
                if (sync_rise) begin
                    state_d    = ST_IDLE;
                    err_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            valid_pend_q <= 1'b0;
            err_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            valid_pend_q <= valid_pend_d;
            err_pend_q   <= err_pend_d;
        end
    end

    logic [3:0]           cmd_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 frame_valid_q;
    logic                 frame_err_q;
    logic [15:0]          frame_count_q;

    // sr_q is still intact here: a new frame needs spi_sync high for two cycles
    // before its falling edge can clear the shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q         <= '0;
            data_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_valid_q <= valid_pend_q;
            frame_err_q   <= err_pend_q;
            if (valid_pend_q) begin
                cmd_q         <= sr_q[FRAME_BITS-1 -: 4];
                data_q        <= sr_q[FRAME_BITS-5 -: DATA_BITS];
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign cmd_out     = cmd_q;
    assign data_dac    = data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != ST_IDLE) | valid_pend_q | err_pend_q;

endmodule

// File: doc/dac_spi_frame_receiver.md
# dac_spi_frame_receiver

Receive-side counterpart of the tone generator's DAC SPI output: it decodes the 24-bit SPI frames (SCLK, SYNC_n, DIN) that drive the on-board DAC and presents the command nibble and 16-bit sample on parallel outputs. It sits on the 100 MHz PLL clock domain in loopback/diagnostic builds, either tapping the DAC pins or replacing the DAC in simulation. Its outputs feed HEX/LED display and self-check logic.

## Interface
- FRAME_BITS, 24: SCLK falling edges per valid frame.
- DATA_BITS, 16: sample width; frame bits [FRAME_BITS-5 -: DATA_BITS].
- SYNC_STAGES, 2: synchronizer flops on each SPI input (≥2).
- clk  in  1  system clock (100 MHz PLL output); single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  SPI serial clock, asynchronous to clk, idles high.
- spi_sync  in  1  frame select, active low (SYNC_n).
- data  in  1  serial data, MSB first, valid on spi_clk falling edge.
- cmd_out  out  4  command nibble, frame bits [23:20]; reset 0.
- data_dac  out  DATA_BITS  last good sample, frame bits [19:4]; reset 0.
- frame_valid  out  1  one-cycle pulse per good frame; reset 0.
- frame_err  out  1  one-cycle pulse per bad frame; reset 0.
- frame_count  out  16  count of good frames, wraps 0xFFFF→0; reset 0.
- busy  out  1  high while a frame is in progress (SHIFT or OVERRUN); reset 0.

## Operation
- spi_clk, spi_sync, data each pass through SYNC_STAGES flops; all logic uses synchronized versions plus one extra history flop for edge detection.
- States: IDLE, SHIFT, OVERRUN.
- IDLE: bit counter = 0. Synchronized spi_sync falling → SHIFT, shift register cleared.
- SHIFT: on each detected spi_clk falling edge, shift register ← {sr[FRAME_BITS-2:0], data_sync}; counter +1. Edge arriving with counter already = FRAME_BITS → OVERRUN.
- OVERRUN: further spi_clk edges ignored.
- spi_sync rising (from SHIFT or OVERRUN) → IDLE, and:
  - SHIFT with counter == FRAME_BITS: load cmd_out, data_dac from shift register; pulse frame_valid; frame_count +1.
  - SHIFT with counter ≠ FRAME_BITS (short frame, incl. 0 bits) or OVERRUN: pulse frame_err; cmd_out/data_dac/frame_count hold.
- Simultaneous spi_clk falling and spi_sync rising in the same synchronized cycle: the clock edge is discarded, frame judged on count before it.
- spi_clk edges while in IDLE are ignored.
- Bits [3:0] of the frame are don't-care, not output.
- reset_n low at any time: immediate return to IDLE, all outputs and counters to 0; a frame in progress is lost, and the frame following reset is received only once spi_sync has been seen high then low.

## Timing
- Input constraint: each spi_clk high and low phase ≥ 2 clk periods and spi_sync high ≥ 2 clk periods (spi_clk ≤ 25 MHz at 100 MHz clk).
- Sample capture: data is taken from the same synchronized cycle that detects the spi_clk fall, so data must be stable ≥ 1 clk around the falling edge at the pins (the DAC protocol guarantees this).
- Latency: frame_valid/frame_err assert exactly SYNC_STAGES+2 clk cycles after the first clk edge sampling spi_sync high at the pin. cmd_out, data_dac and frame_count update in that same cycle.
- Pulses are exactly one clk wide; at most one pulse per frame, never both.
- busy rises SYNC_STAGES+1 cycles after spi_sync falls. It falls in the cycle the pulse asserts.

## Structure
- Shared package dac_spi_pkg: FRAME_BITS/DATA_BITS defaults, command field position constants, AD5681R-style command codes (e.g. CMD_WRITE_UPDATE = 4'h3), and the state enum.
- One natural sub-module: sync_edge_detect (SYNC_STAGES-deep synchronizer plus rise/fall pulse outputs), instantiated for spi_clk and spi_sync; data uses a plain synchronizer.

## Test plan
- Single frame 0x3ABCD0 at 10 MHz SCLK → frame_valid one pulse, cmd_out=4'h3, data_dac=16'hABCD, frame_count=1, frame_err never high.
- 23-bit frame, then 25-bit frame → two frame_err pulses; data_dac/cmd_out keep prior values; frame_count unchanged.
- 65 536 back-to-back good frames with minimum 2-cycle sync gap → frame_count wraps to 0, every frame_valid present, data_dac matches each sample.
- reset_n asserted after 12 bits of frame 0x3FFFF0, released mid-frame → outputs 0 during reset, no pulse for that frame; next full frame 0x312340 → data_dac=16'h1234.
- SCLK edges with spi_sync high, plus a spi_clk fall coincident with spi_sync rise after 24 good bits → no effect in IDLE; coincident frame still valid.
- Latency check, SYNC_STAGES=3: frame_valid exactly 5 clk after pin-level spi_sync rise sampled.
